// File: rtl/sram_responder.sv
// sram_responder: single-port word memory that answers initiator requests
// with reads, byte-strobed writes and fences. The response latency is
// configurable and can optionally be stretched by a pseudo-random wait-state
// generator, which exercises the initiators' stall paths.
module sram_responder #(
  parameter int          mem_depth   = 10,
  parameter int          mem_latency = 1,
  parameter int          wait_mode   = 0,
  parameter logic [7:0]  lfsr_seed   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_fence,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Counter load for a request with no wait states; cnt counts the extra
  // cycles spent in BUSY before the response edge.
  localparam logic [3:0] base_cnt = 4'(mem_latency - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic [7:0]    lfsr;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [0:(1 << mem_depth) - 1];

  logic [mem_depth-1:0] idx;
  logic                 in_range;
  logic                 is_write;
  logic                 accept;
  logic [1:0]           wait_cyc;
  logic [3:0]           load_cnt;
  logic [7:0]           lfsr_next;
  logic [31:0]          read_word;
  logic                 unused_bits;

  assign idx      = mem_addr[mem_depth+1:2];
  assign in_range = (mem_addr[31:mem_depth+2] == '0);
  assign is_write = !mem_fence && (mem_wstrb != 4'b0000);

  // A request is taken either from IDLE or on the response edge of the
  // previous one, which is what gives back-to-back service with no bubble.
  assign accept   = !rst && mem_valid && ((state == IDLE) || (cnt == 4'd0));

  assign wait_cyc  = (wait_mode != 0) ? lfsr[1:0] : 2'b00;
  assign load_cnt  = base_cnt + {2'b00, wait_cyc};
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // The read word is captured at accept, so a write committed on an earlier
  // edge is visible and later request changes cannot disturb the answer.
  assign read_word = (in_range && !mem_fence && !is_write) ? mem[idx] : 32'h0;

  // The instruction flag and the byte offset carry no meaning for a word memory.
  assign unused_bits = ^{mem_instr, mem_addr[1:0]};

  // Storage array: byte-lane writes commit on the accept edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (accept && is_write && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_wstrb[k]) begin
          mem[idx][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
      end
    end
  end

  // Request FSM with registered ready/rdata and the wait-state LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lfsr      <= lfsr_seed;
      rdata_q   <= 32'h0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end else begin
        if (state == BUSY) begin
          mem_ready <= 1'b1;
          mem_rdata <= rdata_q;
        end
        if (mem_valid) begin
          state   <= BUSY;
          cnt     <= load_cnt;
          rdata_q <= read_word;
          lfsr    <= lfsr_next;
        end else begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder: three instances (latency 1, latency 3, and
// latency 1 with random waits) share the request bus, each with its own valid.
// Expected responses go into a scoreboard queue when requests are driven and
// are popped by a monitor whenever any instance raises mem_ready.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  vld;
  logic        fence;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [2:0]  rdy;
  logic [31:0] rd [3];

  typedef struct {
    int          sel;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } vec_t;

  exp_t  sb[$];
  vec_t  tbl[15];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [7:0] lfsr_m;

  always #5 clk = ~clk;

  sram_responder #(.mem_depth(4), .mem_latency(1), .wait_mode(0), .lfsr_seed(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .mem_valid(vld[0]), .mem_fence(fence), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_rdata(rd[0]), .mem_ready(rdy[0]));

  sram_responder #(.mem_depth(4), .mem_latency(3), .wait_mode(0), .lfsr_seed(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .mem_valid(vld[1]), .mem_fence(fence), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_rdata(rd[1]), .mem_ready(rdy[1]));

  sram_responder #(.mem_depth(4), .mem_latency(1), .wait_mode(1), .lfsr_seed(8'hA5)) dut_c (
    .clk(clk), .rst(rst), .mem_valid(vld[2]), .mem_fence(fence), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_rdata(rd[2]), .mem_ready(rdy[2]));

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int sel, input logic f, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] ws);
    fence = f;
    addr  = a;
    wdata = wd;
    wstrb = ws;
    vld   = 3'b000;
    vld[sel] = 1'b1;
  endtask

  // Reference wait-state model: wait comes from the low bits before the shift.
  function automatic int model_latency(input int base);
    int l;
    l = base + int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    return l;
  endfunction

  // One isolated request: valid drops right after the accept edge, then the
  // number of edges until mem_ready is measured against the expected latency.
  task automatic single_req(input int sel, input logic f, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws,
                            input logic [31:0] exp, input int exp_lat, output int lat);
    bit got;
    @(posedge clk);
    #1;
    apply_stimulus(sel, f, a, wd, ws);
    sb.push_back('{sel, exp});
    @(posedge clk);
    #1;
    vld = 3'b000;
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (rdy[sel]) got = 1;
    end
    check_output($sformatf("latency_dut%0d", sel), lat, exp_lat);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rdy[k] === 1'b1) begin
        if (sb.size() == 0) begin
          check_output($sformatf("unexpected_ready_dut%0d", k), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output($sformatf("resp_owner_dut%0d", k), k, e.sel);
          check_output($sformatf("rdata_dut%0d", k), rd[k], e.rdata);
        end
      end else if (!rst) begin
        check_output($sformatf("idle_rdata_dut%0d", k), rd[k], 32'h0);
        check_output($sformatf("ready_known_dut%0d", k), {31'd0, rdy[k]}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int sum_act;
    int sum_exp;
    int late;

    tbl[0]  = '{1'b0, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1]  = '{1'b0, 32'h14,  32'h55555555, 4'hF, 32'h0};
    tbl[2]  = '{1'b0, 32'h20,  32'h11223344, 4'hF, 32'h0};
    tbl[3]  = '{1'b0, 32'h00,  32'hCAFEF00D, 4'hF, 32'h0};
    tbl[4]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 32'h14,  32'h0,        4'h0, 32'h55555555};
    tbl[6]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF};
    tbl[7]  = '{1'b0, 32'h20,  32'hAABBCCDD, 4'b0101, 32'h0};
    tbl[8]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD};
    tbl[9]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[10] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF};
    tbl[11] = '{1'b0, 32'h40,  32'h12345678, 4'hF, 32'h0};
    tbl[12] = '{1'b0, 32'h40,  32'h0,        4'h0, 32'h0};
    tbl[13] = '{1'b0, 32'h00,  32'h0,        4'h0, 32'hCAFEF00D};
    tbl[14] = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h0};

    rst   = 1'b1;
    vld   = 3'b000;
    fence = 1'b0;
    instr = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    wstrb = 4'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_output($sformatf("reset_ready_dut%0d", k), {31'd0, rdy[k]}, 32'd0);
      check_output($sformatf("reset_rdata_dut%0d", k), rd[k], 32'h0);
    end
    #2 rst = 1'b0;

    // Back-to-back stream on the latency-1 instance: one request per cycle.
    $display("[TB] back-to-back table stream");
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      instr = i[0];
      apply_stimulus(0, tbl[i].fence, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb);
      sb.push_back('{0, tbl[i].rdata});
      @(posedge clk);
      #1;
      if (i > 0) check_output($sformatf("b2b_ready_%0d", i), {31'd0, rdy[0]}, 32'd1);
    end
    vld   = 3'b000;
    instr = 1'b0;
    @(posedge clk);
    #1;
    check_output("b2b_last_ready", {31'd0, rdy[0]}, 32'd1);
    @(posedge clk);
    #1;
    check_output("b2b_ready_single_pulse", {31'd0, rdy[0]}, 32'd0);

    // Latency-3 instance: preload, then change the address while busy.
    $display("[TB] fixed latency 3");
    single_req(1, 1'b0, 32'h08, 32'h0BADC0DE, 4'hF, 32'h0, 3, lat);
    single_req(1, 1'b0, 32'h0C, 32'h77777777, 4'hF, 32'h0, 3, lat);
    @(posedge clk);
    #1;
    apply_stimulus(1, 1'b0, 32'h08, 32'h0, 4'h0);
    sb.push_back('{1, 32'h0BADC0DE});
    @(posedge clk);
    #1;
    addr  = 32'h0C;
    fence = 1'b1;
    check_output("lat3_edge0_ready", {31'd0, rdy[1]}, 32'd0);
    @(posedge clk);
    #1;
    check_output("lat3_edge1_ready", {31'd0, rdy[1]}, 32'd0);
    vld   = 3'b000;
    fence = 1'b0;
    @(posedge clk);
    #1;
    check_output("lat3_edge2_ready", {31'd0, rdy[1]}, 32'd0);
    @(posedge clk);
    #1;
    check_output("lat3_edge3_ready", {31'd0, rdy[1]}, 32'd1);
    check_output("lat3_edge3_rdata", rd[1], 32'h0BADC0DE);

    // Asynchronous reset while busy with cnt=2.
    $display("[TB] reset mid-operation");
    @(posedge clk);
    #1;
    apply_stimulus(1, 1'b0, 32'h0C, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    vld = 3'b000;
    #2 rst = 1'b1;
    #1;
    check_output("midrst_ready", {31'd0, rdy[1]}, 32'd0);
    check_output("midrst_rdata", rd[1], 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    late = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rdy[1]) late++;
    end
    check_output("midrst_no_late_ready", late, 0);
    single_req(1, 1'b0, 32'h0C, 32'h0, 4'h0, 32'h77777777, 3, lat);

    // Random wait states against the reference LFSR model.
    $display("[TB] random wait states");
    lfsr_m  = 8'hA5;
    sum_act = 0;
    sum_exp = 0;
    begin
      int el;
      el = model_latency(1);
      single_req(2, 1'b0, 32'h04, 32'h13579BDF, 4'hF, 32'h0, el, lat);
    end
    for (int i = 0; i < 100; i++) begin
      int el;
      el = model_latency(1);
      sum_exp += el;
      single_req(2, 1'b0, 32'h04, 32'h0, 4'h0, 32'h13579BDF, el, lat);
      sum_act += lat;
      check_output($sformatf("wait_range_%0d", i), {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
    end
    check_output("wait_latency_sum", sum_act, sum_exp);

    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Single-port word memory that answers `mem_in_type` requests with `mem_out_type` responses. It sits behind the instruction prefetcher or the data port and is the memory end of the core's memory interface. It serves reads, byte-strobed writes and fences with a configurable latency. An optional pseudo-random wait-state generator stretches that latency so the initiators' stall paths get exercised.

## Interface
Parameters:
- `mem_depth`, default 10: log2 of the number of 32-bit words stored.
- `mem_latency`, default 1, legal 1..8: base cycles from accept to `mem_ready`.
- `wait_mode`, default 0: 0 gives a fixed latency; 1 adds 0..3 pseudo-random wait cycles per request.
- `lfsr_seed`, default 8'hA5: reset value of the wait-state LFSR. It must be nonzero.

Ports:
- `clk`, in, 1: the single clock. All state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `mem_in`, in, `mem_in_type`: request from the initiator. The block uses `mem_valid`, `mem_fence`, `mem_instr`, `mem_addr[31:0]`, `mem_wdata[31:0]` and `mem_wstrb[3:0]`.
- `mem_out`, out, `mem_out_type`: response to the initiator, carrying `mem_rdata[31:0]` and `mem_ready`.

## Operation
- **Storage:** `2**mem_depth` words, indexed by `mem_addr[mem_depth+1:2]`. Contents are not reset.
- **Range check:** a request is in range when `mem_addr[31:mem_depth+2]==0`.
- **Request classes**, decoded at accept:
  - Fence: `mem_fence=1`. No array access. Responds with rdata 0.
  - Write: `mem_fence=0` and `mem_wstrb!=0`.
    - Byte lane k is updated from `wdata[8k+7:8k]` when `wstrb[k]=1`.
    - The write commits on the accept edge. Out-of-range writes are dropped.
    - Responds with rdata 0.
  - Read: every other request.
    - Returns the word at accept time, including any write committed on an earlier edge.
    - Out-of-range reads return 0.
  - `mem_instr` is not used to change behaviour.
- **State machine**, two states:
  - IDLE:
    - If `mem_valid=1`, accept the request and go to BUSY.
    - On accept, capture the class, index and read word, and load `cnt = mem_latency-1+wait`.
  - BUSY:
    - While `cnt!=0`, decrement `cnt`.
    - When `cnt==0`, the next edge drives `mem_ready=1` with the captured rdata.
    - That response edge also samples `mem_in`. If `mem_valid=1`, the new request is accepted (back-to-back) and the block stays in BUSY. Otherwise it goes to IDLE.
- **Request changes while BUSY** are ignored, including `mem_valid` falling, a new address or a new fence. The captured request is still answered. The initiator holds its request until `mem_ready` by protocol.
- **Wait states:**
  - LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifting once per accept.
  - `wait = lfsr[1:0]` when `wait_mode=1`, otherwise 0.
- **Width rules:** `cnt` is 4 bits. `mem_latency-1+3 <= 10` fits without overflow.

## Timing
- **Reset values:** while `rst=1`, `mem_ready=0`, `mem_rdata=0`, state=IDLE, `cnt=0`, `lfsr=lfsr_seed`.
- **Reset mid-operation:** a pending response is discarded, with no `mem_ready` pulse. A write already committed stays committed.
- **Output registers:** both outputs are registered. `mem_ready` is a one-cycle pulse per accepted request. `mem_rdata` is 0 in every cycle where `mem_ready=0`.
- **Latency:** a request accepted at edge t is answered at edge t+`mem_latency`+wait.
  - With `mem_latency=1` and `wait_mode=0`, a continuously valid initiator gets `mem_ready` every cycle, one request per cycle.
- **Back-to-back:** the request visible in the cycle where `mem_ready=1` is accepted on the following edge. It is never lost, and no bubble is inserted beyond the latency.
- **Ordering:** exactly one outstanding request at a time. Responses return in order.

## Test plan
- **Back-to-back reads:** after reset, write 0xDEADBEEF to address 0x10 (`wstrb=4'hF`). Then with `mem_latency=1`, read 0x10, 0x14, 0x10 back-to-back.
  - Expect `mem_ready` 1 in three consecutive cycles.
  - Expect rdata 0xDEADBEEF, then word 5, then 0xDEADBEEF.
- **Byte strobes:** with word 0x20 = 0x11223344, write `wstrb=4'b0101`, `wdata=0xAABBCCDD`. A following read returns 0x11BB33DD.
- **Fixed latency:** with `mem_latency=3`, a read accepted at edge 0 gives `mem_ready=1` only at edge 3.
  - If the address changes at edge 1, the response still carries the edge-0 word.
- **Fence and out of range:** with `mem_depth=4`, a fence request gives rdata 0 and one ready pulse, and memory is unchanged.
  - A write to 0x40 is dropped. A read of 0x40 returns 0, and word 0 is unchanged.
- **Random waits:** with `wait_mode=1` and seed 8'hA5, issue 100 reads.
  - Every latency is in 1..4 cycles, and the sequence is identical across runs.
  - The sum of latencies matches the reference LFSR model.
- **Reset mid-operation:** assert `rst` asynchronously while BUSY with `cnt=2`.
  - `mem_ready` and `mem_rdata` go to 0 immediately, with no late pulse after release.
  - The first request after release is answered with correct latency.
